// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: parses UART byte frames, chains operands through an external ALU, streams replies.
// Define UART_ALU_CTRL_ERR_EN to send a 0xEE reply and pulse error_o on malformed packets.
module uart_alu_ctrl #(
    parameter int OPERAND_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               s_axis_tdata_i,
    input  logic                     s_axis_tvalid_i,
    output logic                     s_axis_tready_o,
    output logic [7:0]               m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic [1:0]               alu_op_o,
    output logic [OPERAND_WIDTH-1:0] alu_a_o,
    output logic [OPERAND_WIDTH-1:0] alu_b_o,
    output logic                     alu_valid_o,
    input  logic                     alu_ready_i,
    input  logic [OPERAND_WIDTH-1:0] alu_result_i,
    input  logic                     alu_result_valid_i,
    output logic                     busy_o,
    output logic                     error_o
);

    // state    | meaning
    // IDLE     | wait opcode          HDR_*    | reserved / length bytes
    // ECHO     | forward payload      OPND     | collect operand bytes
    // ALU_REQ  | request to ALU       ALU_WAIT | wait result strobe
    // TX_RES   | send accumulator     DRAIN    | discard bad payload
    // ERR_TX   | send 0xEE
    localparam int NB = OPERAND_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(NB) + 1;
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    typedef enum logic [3:0] {
        IDLE, HDR_RSV, HDR_LEN0, HDR_LEN1, ECHO, OPND,
        ALU_REQ, ALU_WAIT, TX_RES, DRAIN, ERR_TX
    } state_t;

`ifdef UART_ALU_CTRL_ERR_EN
    localparam state_t AFTER_DRAIN = ERR_TX;
    logic err_q;
    assign error_o = err_q;
`else
    localparam state_t AFTER_DRAIN = IDLE;
    assign error_o = 1'b0;
`endif

    state_t                   state_q;
    logic [7:0]               opcode_q;
    logic [7:0]               len_lo_q;
    logic [15:0]              rem_q;
    logic [TW-1:0]            timer_q;
    logic [BW-1:0]            idx_q;
    logic                     first_q;
    logic [OPERAND_WIDTH-1:0] acc_q;
    logic [OPERAND_WIDTH-9:0] opnd_q;
    logic [OPERAND_WIDTH-9:0] tx_shift_q;
    logic [7:0]               tx_data_q;
    logic                     tx_valid_q;
    logic                     alu_valid_q;
    logic [OPERAND_WIDTH-1:0] alu_a_q;
    logic [OPERAND_WIDTH-1:0] alu_b_q;
    logic [1:0]               alu_op_q;
    logic [1:0]               op_sel_q;

    logic                     ready_raw;
    logic                     timed;
    logic                     accept;
    logic [15:0]              len_full;
    logic [15:0]              pay_len;
    logic                     len_short;
    logic                     hdr_bad;
    logic [1:0]               op_sel;
    logic [OPERAND_WIDTH-1:0] opnd_next;

    always_comb begin
        ready_raw = 1'b0;
        timed     = 1'b0;
        case (state_q)
            IDLE:                                     ready_raw = 1'b1;
            HDR_RSV, HDR_LEN0, HDR_LEN1, OPND, DRAIN: begin
                ready_raw = 1'b1;
                timed     = 1'b1;
            end
            ECHO: begin
                ready_raw = m_axis_tready_i;
                timed     = 1'b1;
            end
            default: ;
        endcase
    end

    // No byte is taken while reset is held, so nothing is lost to a reset cycle.
    assign s_axis_tready_o = ready_raw && !rst_i;
    assign accept          = s_axis_tvalid_i && s_axis_tready_o;

    assign len_full  = {s_axis_tdata_i, len_lo_q};
    assign pay_len   = len_full - 16'd4;
    assign len_short = len_full < 16'd4;
    assign opnd_next = {s_axis_tdata_i, opnd_q};

    always_comb begin
        op_sel  = 2'd2;
        hdr_bad = 1'b1;
        case (opcode_q)
            8'hEC: hdr_bad = len_short;
            8'hA0, 8'hB0, 8'hC0: begin
                op_sel  = (opcode_q == 8'hA0) ? 2'd0 : (opcode_q == 8'hB0) ? 2'd1 : 2'd2;
                hdr_bad = len_short || (pay_len == 16'd0) || ((pay_len % 16'(NB)) != 16'd0);
            end
            default: ;
        endcase
    end

    assign m_axis_tvalid_o = (state_q == ECHO) ? s_axis_tvalid_i : tx_valid_q;
    assign m_axis_tdata_o  = (state_q == ECHO) ? s_axis_tdata_i  : tx_data_q;
    assign alu_valid_o     = alu_valid_q;
    assign alu_a_o         = alu_a_q;
    assign alu_b_o         = alu_b_q;
    assign alu_op_o        = alu_op_q;
    assign busy_o          = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            rem_q       <= '0;
            timer_q     <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            tx_shift_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            op_sel_q    <= '0;
`ifdef UART_ALU_CTRL_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef UART_ALU_CTRL_ERR_EN
            err_q <= 1'b0;
`endif
            if (timed && !accept && timer_q == '0) begin
                state_q <= IDLE;
            end else begin
                if (timed) timer_q <= accept ? TO_LOAD : timer_q - TW'(1);
                case (state_q)
                    IDLE: if (accept) begin
                        opcode_q <= s_axis_tdata_i;
                        timer_q  <= TO_LOAD;
                        state_q  <= HDR_RSV;
                    end
                    HDR_RSV: if (accept) state_q <= HDR_LEN0;
                    HDR_LEN0: if (accept) begin
                        len_lo_q <= s_axis_tdata_i;
                        state_q  <= HDR_LEN1;
                    end
                    HDR_LEN1: if (accept) begin
                        rem_q    <= len_short ? 16'd0 : pay_len;
                        idx_q    <= '0;
                        first_q  <= 1'b1;
                        op_sel_q <= op_sel;
                        if (hdr_bad) begin
`ifdef UART_ALU_CTRL_ERR_EN
                            err_q <= 1'b1;
`endif
                            state_q <= (len_short || pay_len == 16'd0) ? AFTER_DRAIN : DRAIN;
                        end else if (opcode_q == 8'hEC) begin
                            state_q <= (pay_len == 16'd0) ? IDLE : ECHO;
                        end else begin
                            state_q <= OPND;
                        end
                    end
                    ECHO: if (accept) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) state_q <= IDLE;
                    end
                    OPND: if (accept) begin
                        rem_q  <= rem_q - 16'd1;
                        opnd_q <= opnd_next[OPERAND_WIDTH-1:8];
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            first_q <= 1'b0;
                            if (first_q) begin
                                acc_q <= opnd_next;
                                if (rem_q == 16'd1) state_q <= TX_RES;
                            end else begin
                                alu_a_q     <= acc_q;
                                alu_b_q     <= opnd_next;
                                alu_op_q    <= op_sel_q;
                                alu_valid_q <= 1'b1;
                                state_q     <= ALU_REQ;
                            end
                        end else begin
                            idx_q <= idx_q + BW'(1);
                        end
                    end
                    ALU_REQ: if (alu_ready_i) begin
                        alu_valid_q <= 1'b0;
                        state_q     <= ALU_WAIT;
                    end
                    ALU_WAIT: if (alu_result_valid_i) begin
                        acc_q   <= alu_result_i;
                        state_q <= (rem_q == 16'd0) ? TX_RES : OPND;
                    end
                    TX_RES: begin
                        if (!tx_valid_q) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= acc_q[7:0];
                            tx_shift_q <= acc_q[OPERAND_WIDTH-1:8];
                        end else if (m_axis_tready_i) begin
                            if (idx_q == LAST_IDX) begin
                                tx_valid_q <= 1'b0;
                                idx_q      <= '0;
                                state_q    <= IDLE;
                            end else begin
                                tx_data_q  <= tx_shift_q[7:0];
                                tx_shift_q <= tx_shift_q >> 8;
                                idx_q      <= idx_q + BW'(1);
                            end
                        end
                    end
                    DRAIN: if (accept) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) state_q <= AFTER_DRAIN;
                    end
`ifdef UART_ALU_CTRL_ERR_EN
                    ERR_TX: begin
                        if (!tx_valid_q) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'hEE;
                        end else if (m_axis_tready_i) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: directed test-plan packets followed by random frames.
module tb_uart_alu_ctrl;
    localparam int W  = 32;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [7:0]     s_axis_tdata_i;
    logic           s_axis_tvalid_i;
    logic           s_axis_tready_o;
    logic [7:0]     m_axis_tdata_o;
    logic           m_axis_tvalid_o;
    logic           m_axis_tready_i;
    logic [1:0]     alu_op_o;
    logic [W-1:0]   alu_a_o;
    logic [W-1:0]   alu_b_o;
    logic           alu_valid_o;
    logic           alu_ready_i;
    logic [W-1:0]   alu_result_i;
    logic           alu_result_valid_i;
    logic           busy_o;
    logic           error_o;

    always #5 clk = ~clk;

    uart_alu_ctrl #(.OPERAND_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
        .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_valid_o(alu_valid_o),
        .alu_ready_i(alu_ready_i), .alu_result_i(alu_result_i), .alu_result_valid_i(alu_result_valid_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } alu_txn_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pkt[$];
    logic [7:0] exp_tx[$];
    alu_txn_t   exp_alu[$];
    int         exp_err = 0;
    int         err_pulses = 0;
    int         alu_delay = 0;
    bit         stall_arm = 0;
    int         stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    function automatic logic [W-1:0] word_at(input int base);
        return {pkt[base+3], pkt[base+2], pkt[base+1], pkt[base]};
    endfunction

    // Reference model: whole-packet semantics straight from the frame rules.
    task automatic model_pkt();
        logic [7:0] opc;
        int         len;
        int         pay;
        logic [1:0] op;
        logic [W-1:0] acc;
        logic [W-1:0] w;
        alu_txn_t   t;
        opc = pkt[0];
        len = int'({pkt[3], pkt[2]});
        pay = len - 4;
        if (len >= 4 && opc == 8'hEC) begin
            for (int i = 0; i < pay; i++) exp_tx.push_back(pkt[4+i]);
        end else if (len >= 4 && (opc == 8'hA0 || opc == 8'hB0 || opc == 8'hC0) && pay > 0 && pay % 4 == 0) begin
            op  = (opc == 8'hA0) ? 2'd0 : (opc == 8'hB0) ? 2'd1 : 2'd2;
            acc = word_at(4);
            for (int k = 1; k < pay / 4; k++) begin
                w   = word_at(4 + 4 * k);
                t.op = op; t.a = acc; t.b = w;
                exp_alu.push_back(t);
                acc = alu_fn(op, acc, w);
            end
            for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8*i +: 8]);
        end else begin
            exp_err++;
`ifdef UART_ALU_CTRL_ERR_EN
            exp_tx.push_back(8'hEE);
`endif
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send_stream(input int gap_max);
        int guard;
        bit acc;
        foreach (pkt[i]) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            s_axis_tvalid_i = 1'b1;
            s_axis_tdata_i  = pkt[i];
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 1000) begin
                @(negedge clk); #2;
                acc = s_axis_tready_o;
                @(posedge clk); #1;
                guard++;
            end
            s_axis_tvalid_i = 1'b0;
            if (!acc) begin
                n_checks++; n_errors++;
                $display("FAIL send_byte: not accepted after %0d cycles, required acceptance", guard);
            end
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_o || exp_tx.size() != 0) && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_idle_expired", (guard >= 5000), 0);
        check("alu_pending", exp_alu.size(), 0);
    endtask

    task automatic run_pkt(input int gap_max);
        model_pkt();
        send_stream(gap_max);
        wait_idle();
    endtask

    task automatic gen_random();
        int         kind;
        int         n;
        int         len;
        logic [7:0] opc;
        logic [7:0] bad_ops[4];
        logic [7:0] all_ops[4];
        bad_ops = '{8'h00, 8'h55, 8'hA1, 8'hFF};
        all_ops = '{8'hEC, 8'hA0, 8'hB0, 8'hC0};
        kind = $urandom_range(0, 5);
        case (kind)
            0: begin opc = 8'hEC; n = $urandom_range(0, 8); len = n + 4; end
            1, 2, 3: begin
                opc = (kind == 1) ? 8'hA0 : (kind == 2) ? 8'hB0 : 8'hC0;
                n = 4 * $urandom_range(1, 4); len = n + 4;
            end
            4: begin opc = bad_ops[$urandom_range(0, 3)]; n = $urandom_range(0, 5); len = n + 4; end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    opc = all_ops[$urandom_range(0, 3)]; len = $urandom_range(0, 3); n = 0;
                end else begin
                    opc = all_ops[$urandom_range(1, 3)]; n = $urandom_range(0, 7);
                    if (n == 4) n = 5;
                    len = n + 4;
                end
            end
        endcase
        pkt.delete();
        pkt.push_back(opc);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        pkt.push_back(8'(len >> 8));
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    // TX sink and monitor.
    initial begin
        bit         hold;
        logic [7:0] held;
        hold = 1'b0;
        held = '0;
        m_axis_tready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                m_axis_tready_i = 1'b0;
                stall_left--;
            end else if (stall_arm && m_axis_tvalid_o) begin
                stall_arm = 1'b0;
                stall_left = 19;
                m_axis_tready_i = 1'b0;
            end else begin
                m_axis_tready_i = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (rst_i) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("tx_hold_valid", m_axis_tvalid_o, 1);
                    check("tx_hold_data", m_axis_tdata_o, held);
                end
                if (m_axis_tvalid_o && m_axis_tready_i) begin
                    if (exp_tx.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL tx_unexpected: got byte %0h, required no byte", m_axis_tdata_o);
                    end else begin
                        check("tx_byte", m_axis_tdata_o, exp_tx.pop_front());
                    end
                    hold = 1'b0;
                end else if (m_axis_tvalid_o) begin
                    check("rx_ready_while_tx_stalled", s_axis_tready_o, 0);
                    hold = 1'b1;
                    held = m_axis_tdata_o;
                end else begin
                    hold = 1'b0;
                end
                if (error_o) err_pulses++;
            end
        end
    end

    // ALU model: delayed accept, result strobe a few cycles later.
    initial begin
        int         wait_cnt;
        int         res_delay;
        alu_txn_t   e;
        logic [W-1:0] r;
        wait_cnt = 0;
        alu_ready_i = 1'b0;
        alu_result_valid_i = 1'b0;
        alu_result_i = '0;
        forever begin
            @(negedge clk); #1;
            if (alu_valid_o && !rst_i) begin
                if (wait_cnt < alu_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    alu_ready_i = 1'b1;
                    r = alu_fn(alu_op_o, alu_a_o, alu_b_o);
                    if (exp_alu.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL alu_unexpected: got request a=%0h b=%0h, required none", alu_a_o, alu_b_o);
                    end else begin
                        e = exp_alu.pop_front();
                        check("alu_op", alu_op_o, e.op);
                        check("alu_a", alu_a_o, e.a);
                        check("alu_b", alu_b_o, e.b);
                    end
                    @(posedge clk); #1;
                    alu_ready_i = 1'b0;
                    res_delay = $urandom_range(0, 3);
                    repeat (res_delay) begin @(posedge clk); #1; end
                    alu_result_i = r;
                    alu_result_valid_i = 1'b1;
                    @(posedge clk); #1;
                    alu_result_valid_i = 1'b0;
                    alu_result_i = W'($urandom);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid_o, 0);
        check({tag, "_m_tdata"}, m_axis_tdata_o, 0);
        check({tag, "_alu_valid"}, alu_valid_o, 0);
        check({tag, "_alu_a"}, alu_a_o, 0);
        check({tag, "_alu_b"}, alu_b_o, 0);
        check({tag, "_alu_op"}, alu_op_o, 0);
        check({tag, "_error"}, error_o, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        s_axis_tvalid_i = 1'b0;
        s_axis_tdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_rx_ready_held", s_axis_tready_o, 0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("idle_rx_ready", s_axis_tready_o, 1);

        // Echo with TX back-pressure.
        stall_arm = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        run_pkt(1);

        // Add chain, delayed ALU accept, stalled result transmit.
        alu_delay = 5;
        stall_arm = 1'b1;
        pkt = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        run_pkt(1);
        alu_delay = 0;

        // Single operand: no ALU traffic.
        pkt = '{8'hB0, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_pkt(0);

        // Malformed, then recovery.
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_pkt(0);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7F};
        run_pkt(0);

        // Timeout mid-operand: busy stays high for TO-1 idle cycles, falls on the TO-th.
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
        send_stream(0);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("timeout_still_busy", busy_o, 1);
        @(posedge clk); #1;
        check("timeout_idle", busy_o, 0);
        check("timeout_no_tx", m_axis_tvalid_o, 0);
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        run_pkt(0);

        // Reset mid-OPND; alu_a still holds 3 from the add chain.
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        send_stream(0);
        check("pre_reset_busy", busy_o, 1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_i = 1'b0;
        #1;
        check("post_reset_rx_ready", s_axis_tready_o, 1);
        @(posedge clk); #1;
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        run_pkt(0);

        // Random frames.
        for (int p = 0; p < 40; p++) begin
            gen_random();
            alu_delay = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) stall_arm = 1'b1;
            run_pkt(3);
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_tx_queue", exp_tx.size(), 0);
        check("final_alu_queue", exp_alu.size(), 0);
        check("error_pulses", err_pulses,
`ifdef UART_ALU_CTRL_ERR_EN
              exp_err
`else
              0
`endif
        );
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
